fetch_queue: RTL and testbench

//  Small in-order FIFO between instruction fetch (PC + instruction memory) and decode.

---
 rtl/fetch_queue.sv | 125 ++++++++++++
 tb/tb_fetch_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: in-order FIFO of {PC, instruction} pairs between fetch and decode.
//
// Optional feature macro: FETCHQ_BYPASS_EN
//   When defined, an instruction pushed into an empty queue appears on the
//   Pop* outputs in the same cycle. If decode also takes it that cycle, it is
//   never written into storage.
//
// Parameters
//   DW     width of PC and instruction words
//   DEPTH  number of entries (power of 2, >= 2)
//   AW     pointer width, log2(DEPTH)
//
// Ports
//   Clk        rising-edge clock
//   Reset      asynchronous active-high reset
//   Flush      synchronous queue flush; wins over push and pop
//   PushValid  fetch presents {PushPC, PushInstr}
//   PushPC     PC of the fetched instruction
//   PushInstr  fetched instruction word
//   PCWrite    PC advance enable, equal to !Full
//   PopReady   decode consumes the head entry when PopValid=1
//   PopValid   head entry is valid
//   PopPC      PC of the head entry, 0 when empty
//   PopInstr   instruction of the head entry, 0 when empty
//   Count      number of valid entries, 0..DEPTH
module fetch_queue #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Flush,
  input  logic          PushValid,
  input  logic [DW-1:0] PushPC,
  input  logic [DW-1:0] PushInstr,
  output logic          PCWrite,
  input  logic          PopReady,
  output logic          PopValid,
  output logic [DW-1:0] PopPC,
  output logic [DW-1:0] PopInstr,
  output logic [AW:0]   Count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Each entry packs {pc, instr}.
  logic [DEPTH-1:0][2*DW-1:0] entry;
  logic [AW-1:0]              rd_ptr, wr_ptr;
  logic [AW:0]                cnt;

  logic full, empty;
  logic push, pop;
  logic direct;  // bypassed entry consumed straight from the push port

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  // Depends on the occupancy only, so there is no combinational path from
  // PushValid or PopReady to the PC enable.
  assign PCWrite = !full;
  assign Count   = cnt;

`ifdef FETCHQ_BYPASS_EN
  logic byp;
  assign byp    = empty & PushValid & !Flush;
  assign direct = byp & PopReady;

  always_comb begin
    PopValid = 1'b0;
    PopPC    = '0;
    PopInstr = '0;
    if (!empty) begin
      PopValid = 1'b1;
      {PopPC, PopInstr} = entry[rd_ptr];
    end else if (byp) begin
      PopValid = 1'b1;
      PopPC    = PushPC;
      PopInstr = PushInstr;
    end
  end
`else
  assign direct = 1'b0;

  always_comb begin
    PopValid = 1'b0;
    PopPC    = '0;
    PopInstr = '0;
    if (!empty) begin
      PopValid = 1'b1;
      {PopPC, PopInstr} = entry[rd_ptr];
    end
  end
`endif

  // Stored pop only: a bypassed handoff never touches the pointers.
  assign push = PushValid & !full & !direct;
  assign pop  = !empty & PopReady;

  // Storage is not reset; only entries between the pointers are observable.
  always_ff @(posedge Clk) begin
    if (push && !Flush)
      entry[wr_ptr] <= {PushPC, PushInstr};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue (default DW=32, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
// later, well before the next rising edge.
module tb_fetch_queue;

  logic        Clk = 1'b0;
  logic        Reset, Flush, PushValid, PopReady;
  logic [31:0] PushPC, PushInstr;
  logic        PCWrite, PopValid;
  logic [31:0] PopPC, PopInstr;
  logic [2:0]  Count;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.DW(32), .DEPTH(4), .AW(2)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .PushValid(PushValid), .PushPC(PushPC), .PushInstr(PushInstr),
    .PCWrite(PCWrite), .PopReady(PopReady), .PopValid(PopValid),
    .PopPC(PopPC), .PopInstr(PopInstr), .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic pr, input logic fl);
    PushValid = pv;
    PushPC    = pc;
    PushInstr = 32'h1000_0000 | pc;
    PopReady  = pr;
    Flush     = fl;
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #12;
    Reset = 1'b0;
    @(posedge Clk); #1;

    // reset state
    chk("rst_count",   32'(Count),    32'd0);
    chk("rst_popvalid",32'(PopValid), 32'd0);
    chk("rst_poppc",   PopPC,         32'd0);
    chk("rst_pcwrite", 32'(PCWrite),  32'd1);

    // fill and stall
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i*4), 1'b0, 1'b0);
      chk("fill_pcwrite", 32'(PCWrite), 32'd1);
      tick();
    end
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    chk("full_count",   32'(Count),   32'd4);
    chk("full_pcwrite", 32'(PCWrite), 32'd0);
    tick();
    chk("drop_count",   32'(Count),   32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain_valid", 32'(PopValid), 32'd1);
      chk("drain_pc",    PopPC,         32'(i*4));
      chk("drain_instr", PopInstr,      32'h1000_0000 | 32'(i*4));
      tick();
    end
    chk("drain_count", 32'(Count),    32'd0);
    chk("drain_empty", 32'(PopValid), 32'd0);

    // wrap-around: one entry resident, then push and pop every cycle
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 32'(k*4), 1'b1, 1'b0);
      chk("wrap_count", 32'(Count), 32'd1);
      chk("wrap_pc",    PopPC,      32'((k-1)*4));
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("wrap_last_pc", PopPC, 32'h28);
    tick();
    chk("wrap_end_count", 32'(Count), 32'd0);

    // flush priority over push and pop
    drive(1'b1, 32'h50, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h54, 1'b0, 1'b0); tick();
    chk("flush_pre_count", 32'(Count), 32'd2);
    drive(1'b1, 32'h40, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_count",   32'(Count),    32'd0);
    chk("flush_valid",   32'(PopValid), 32'd0);
    chk("flush_pcwrite", 32'(PCWrite),  32'd1);
    tick();
    chk("flush_no40_valid", 32'(PopValid), 32'd0);
    chk("flush_no40_pc",    PopPC,         32'd0);

    // full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h60 + 32'(i*4), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h70, 1'b1, 1'b0);
    chk("fullpop_pcwrite", 32'(PCWrite), 32'd0);
    chk("fullpop_head",    PopPC,        32'h60);
    tick();
    chk("fullpop_count",   32'(Count),   32'd3);
    drive(1'b1, 32'h70, 1'b0, 1'b0);
    chk("retry_pcwrite",   32'(PCWrite), 32'd1);
    tick();
    chk("retry_count",     32'(Count),   32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fullpop_drain_pc", PopPC, 32'h64 + 32'(i*4));
      tick();
    end
    chk("fullpop_drain_count", 32'(Count), 32'd0);

    // push into empty queue with decode ready
    drive(1'b1, 32'h80, 1'b1, 1'b0);
`ifdef FETCHQ_BYPASS_EN
    chk("empty_push_valid", 32'(PopValid), 32'd1);
    chk("empty_push_pc",    PopPC,         32'h80);
`else
    chk("empty_push_valid", 32'(PopValid), 32'd0);
    chk("empty_push_pc",    PopPC,         32'd0);
`endif
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef FETCHQ_BYPASS_EN
    chk("empty_next_count", 32'(Count),    32'd0);
    chk("empty_next_valid", 32'(PopValid), 32'd0);
`else
    chk("empty_next_count", 32'(Count),    32'd1);
    chk("empty_next_pc",    PopPC,         32'h80);
    chk("empty_next_valid", 32'(PopValid), 32'd1);
    // Pop* hold while stalled
    tick();
    chk("stall_hold_pc",    PopPC,         32'h80);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("empty_drained", 32'(Count), 32'd0);
    // empty with PopReady held: nothing changes
    tick();
    chk("empty_popready_count", 32'(Count), 32'd0);

    // asynchronous reset mid-stream with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h90 + 32'(i*4), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(Count), 32'd3);
    #1;
    Reset = 1'b1;
    #1;
    chk("async_rst_count",    32'(Count),    32'd0);
    chk("async_rst_valid",    32'(PopValid), 32'd0);
    chk("async_rst_poppc",    PopPC,         32'd0);
    chk("async_rst_pcwrite",  32'(PCWrite),  32'd1);
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    chk("post_rst_count", 32'(Count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
